fruit_spawn_scheduler: RTL
==========================

// Module: fruit_spawn_scheduler
// PURPOSE
//   Schedules which on-screen object slots are in flight. Sits between game control and the per-slot
//   objectTransition/objectOutOfBound/displayObj chains: on a periodic spawn tick it claims a free
//   slot, picks a pseudo-random launch point and direction, and pulses that slot's re-init.
//   Frees slots on out-of-bound or slice. Keeps score, miss count and game-over.
// PARAMETERS
//   N_SLOTS       4           object slots managed (1..8)
//   SPAWN_PERIOD  25_000_000  clk cycles between spawn ticks (>=2)
//   SCREEN_H      480         vertical resolution; launch row = SCREEN_H - OBJ_H
//   OBJ_H         80          sprite height in pixels
//   MAX_MISS      3           misses that trigger game_over (1..15)
// PORTS
//   clk          in   1          pixel-domain clock (Div[0])
//   rst_n        in   1          asynchronous reset, active low
//   en           in   1          game running; gates the spawn timer
//   oob          in   N_SLOTS    per-slot out-of-bound flag, level
//   sliced       in   N_SLOTS    per-slot hit pulse from cut detection
//   slot_active  out  N_SLOTS    slot in LAUNCH or FLY; drives displayObj en
//   slot_rst     out  N_SLOTS    one-cycle re-init pulse to objectTransition rst
//   init_posx    out  N_SLOTS*10 launch column per slot, held until next launch
//   init_posy    out  N_SLOTS*9  launch row per slot
//   dir_x        out  N_SLOTS    horizontal direction per slot (1 = right)
//   score        out  8          slices, saturates at 255
//   miss         out  4          misses, saturates at 15
//   game_over    out  1          sticky; set when miss reaches MAX_MISS
// BEHAVIOUR
//   Reset: all slots IDLE; all outputs 0; timer 0; LFSR = 16'hACE1.
//   LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of en.
//   Timer: while en && !game_over, counts 0..SPAWN_PERIOD-1 and wraps. Otherwise forced to 0.
//     tick = timer at SPAWN_PERIOD-1.
//   Spawn on tick: claim the lowest-index slot that is IDLE in registered state.
//     A slot freed in the same cycle is not eligible.
//     No free slot: the tick is dropped silently; nothing is queued.
//   Claim values, latched in the same edge:
//     init_posx = {1'b0, lfsr[8:0]} (0..511, always <= 640-100)
//     dir_x = lfsr[9]
//     init_posy = SCREEN_H - OBJ_H
//   Per-slot FSM:
//     IDLE -> LAUNCH on claim.
//     LAUNCH (exactly 1 cycle, slot_rst = 1; oob/sliced ignored) -> FLY.
//     FLY -> IDLE on sliced or oob.
//       sliced: score += 1.
//       oob && !sliced: miss += 1.
//       Both in the same cycle: counts as a slice only.
//   Simultaneous events on multiple slots in one cycle: all are counted. score adds popcount, saturating.
//   game_over: set the cycle after miss >= MAX_MISS. Blocks new spawns.
//     Slots in FLY finish normally. Counters keep updating (saturating).
//   en low mid-flight: no new spawns; in-flight slots still complete.
//   Async reset mid-flight: every slot returns to IDLE immediately and slot_rst drops.
//   Latency: tick edge -> slot_rst high 1 cycle later; slot_active high from the same edge.
// STRUCTURE
//   Package fruit_pkg:
//     slot_state_t enum {IDLE, LAUNCH, FLY}
//     LFSR_SEED, LFSR_TAPS
//     SCREEN_W = 640, SCREEN_H = 480
//   Sub-module spawn_lfsr (clk, rst_n, out[15:0]).
//   Per-slot FSMs in a generate loop. Priority encoder and popcount are combinational in the top.
// TESTING (bench uses SPAWN_PERIOD=8, N_SLOTS=4, MAX_MISS=3)
//   1. Reset then en=1:
//      - first tick at cycle 8 claims slot0
//      - slot_rst=4'b0001 for 1 cycle, then slot_active=4'b0001
//      - init_posy=400; init_posx/dir_x match the LFSR model
//   2. en=1, no oob/sliced for 40 cycles:
//      - slots 0,1,2,3 claimed at ticks 1..4
//      - 5th tick dropped; slot_active stays 4'hF
//   3. sliced[1] and oob[1] in the same cycle while slot1 in FLY: score +1, miss unchanged, slot1 -> IDLE.
//   4. oob[2] pulsed 3 times on separate flights:
//      - miss = 3, game_over = 1 next cycle
//      - no further slot_rst pulses while en stays 1
//   5. Slot0 freed exactly on a tick cycle: the tick claims slot1 (or drops if all busy), not slot0.
//   6. Assert rst_n low mid-LAUNCH: slot_rst and slot_active clear asynchronously; score/miss = 0.
//      Spawning restarts 8 cycles after release.

Source files
------------

// File: rtl/fruit_pkg.sv
// Shared definitions for the fruit spawn scheduler.
//   slot_state_t : per-slot lifecycle (IDLE -> LAUNCH -> FLY -> IDLE)
//   LFSR_SEED    : value loaded into the launch-point LFSR on reset
//   LFSR_TAPS    : feedback mask for the right-shifting Fibonacci LFSR
//                  (polynomial taps 16,14,13,11 -> state bits 0,2,3,5)
//   SCREEN_W/H   : display resolution in pixels
package fruit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FLY    = 2'd2
  } slot_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying launch column and direction.
// Advances every clock, independent of game state, so the launch point
// depends on how long the player has been around.
//   clk   in   clock
//   rst_n in   asynchronous reset, active low (loads LFSR_SEED)
//   out   out  current LFSR state
module spawn_lfsr
  import fruit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift right; feedback is the parity of the tapped bits, entering at the MSB.
  assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Object-slot scheduler for the fruit game.
// A periodic spawn tick claims the lowest-index idle slot, latches a
// pseudo-random launch column/direction for it and pulses its re-init.
// Slots return to idle when they leave the screen or are sliced; slices
// and misses are counted (saturating) and enough misses end the game.
//   clk          in   pixel-domain clock
//   rst_n        in   asynchronous reset, active low
//   en           in   game running; gates the spawn timer
//   oob          in   per-slot out-of-bound level
//   sliced       in   per-slot hit pulse
//   slot_active  out  slot in LAUNCH or FLY
//   slot_rst     out  one-cycle re-init pulse (slot in LAUNCH)
//   init_posx    out  launch column per slot, 10 bits each
//   init_posy    out  launch row per slot, 9 bits each
//   dir_x        out  horizontal direction per slot (1 = right)
//   score        out  slice count, saturates at 255
//   miss         out  miss count, saturates at 15
//   game_over    out  sticky end-of-game flag
module fruit_spawn_scheduler
  import fruit_pkg::*;
#(
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned SPAWN_PERIOD = 25_000_000,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned OBJ_H        = 80,
  parameter int unsigned MAX_MISS     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_SLOTS-1:0]      oob,
  input  logic [N_SLOTS-1:0]      sliced,
  output logic [N_SLOTS-1:0]      slot_active,
  output logic [N_SLOTS-1:0]      slot_rst,
  output logic [N_SLOTS*10-1:0]   init_posx,
  output logic [N_SLOTS*9-1:0]    init_posy,
  output logic [N_SLOTS-1:0]      dir_x,
  output logic [7:0]              score,
  output logic [3:0]              miss,
  output logic                    game_over
);

  localparam int unsigned TW = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_PERIOD - 1);
  localparam logic [8:0]    LAUNCH_ROW = 9'(SCREEN_H - OBJ_H);
  localparam logic [N_SLOTS-1:0] ONE_SLOT = N_SLOTS'(1);

  function automatic logic [3:0] popcnt(input logic [N_SLOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_SLOTS; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  logic [15:0]        lfsr;
  logic               unused_lfsr;
  logic [TW-1:0]      timer_q, timer_d;
  logic               run, tick;
  logic [N_SLOTS-1:0] idle_vec, claim, slice_ev, miss_ev;
  logic [7:0]         score_q, score_d;
  logic [3:0]         miss_q, miss_d;
  logic               go_q, go_d;

  spawn_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  // Only the low ten LFSR bits feed the launch point.
  assign unused_lfsr = ^lfsr[15:10];

  // Spawn timer: free-runs while the game is live, parked at 0 otherwise.
  assign run  = en && !go_q;
  assign tick = run && (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = '0;
    if (run && !tick) timer_d = timer_q + TW'(1);
  end

  // Lowest-set-bit isolate acts as the priority encoder over idle slots.
  // idle_vec is decoded from registered state, so a slot freed this cycle
  // is still seen as busy.
  assign claim = tick ? (idle_vec & (~idle_vec + ONE_SLOT)) : '0;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    slot_state_t st_q, st_d;
    logic [9:0]  posx_q;
    logic [8:0]  posy_q;
    logic        dir_q;

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        IDLE:    if (claim[g]) st_d = LAUNCH;
        LAUNCH:  st_d = FLY;
        FLY:     if (sliced[g] || oob[g]) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= IDLE;
        posx_q <= '0;
        posy_q <= '0;
        dir_q  <= 1'b0;
      end else begin
        st_q <= st_d;
        if (claim[g]) begin
          posx_q <= {1'b0, lfsr[8:0]};
          posy_q <= LAUNCH_ROW;
          dir_q  <= lfsr[9];
        end
      end
    end

    assign idle_vec[g]           = (st_q == IDLE);
    assign slot_active[g]        = (st_q != IDLE);
    assign slot_rst[g]           = (st_q == LAUNCH);
    // A slice wins over a simultaneous out-of-bound.
    assign slice_ev[g]           = (st_q == FLY) && sliced[g];
    assign miss_ev[g]            = (st_q == FLY) && oob[g] && !sliced[g];
    assign init_posx[g*10 +: 10] = posx_q;
    assign init_posy[g*9 +: 9]   = posy_q;
    assign dir_x[g]              = dir_q;
  end

  always_comb begin
    score_d = sat_add8(score_q, popcnt(slice_ev));
    miss_d  = sat_add4(miss_q, popcnt(miss_ev));
    go_d    = go_q || (miss_q >= 4'(MAX_MISS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      score_q <= '0;
      miss_q  <= '0;
      go_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      go_q    <= go_d;
    end
  end

  assign score     = score_q;
  assign miss      = miss_q;
  assign game_over = go_q;

endmodule
